// File: rtl/vgasync_scaled.sv
`timescale 1ns/1ps
// vgasync_scaled
// VGA timing generator for the vdp99 display path. Free-running hpos/vpos
// counters produce registered sync, blanking, window and VDP coordinate
// outputs. Native VDP pixels are replicated HREP clocks wide and VREP lines
// tall. In text mode the active window is narrowed by TXTPAD clocks per side.
// The mode is latched only at the frame boundary.
//
// Optional feature macro: VGASYNC_PREFETCH_EN. When it is defined, a second
// counter set runs PF clocks ahead and drives the fetch_* look-ahead outputs.
// When it is undefined, the fetch_* outputs are tied to 0.
//
// Ports:
//   clk        in   pixel clock
//   reset      in   synchronous, active-high
//   text_mode  in   request narrow active window (takes effect next frame)
//   hsync      out  horizontal sync, active level HSPOL
//   vsync      out  vertical sync, active level VSPOL
//   vid_active out  pixel inside the active window
//   border     out  visible but not active
//   col        out  VDP pixel x within the active window
//   row        out  VDP line y
//   pix_en     out  first clock of each VDP pixel
//   eof        out  one-clock pulse at the last clock of the last active line
//   fetch_en   out  pix_en, PF clocks early
//   fetch_col  out  col, PF clocks early
//   fetch_row  out  row, PF clocks early
// All outputs describe counter state (h,v) on the clock after the counters
// hold (h,v).
module vgasync_scaled #(
   parameter int HVID   = 512,
   parameter int HRB    = 64,
   parameter int HFP    = 16,
   parameter int HS     = 96,
   parameter int HBP    = 48,
   parameter int HLB    = 64,
   parameter int VVID   = 384,
   parameter int VBB    = 24,
   parameter int VFP    = 10,
   parameter int VS     = 2,
   parameter int VBP    = 33,
   parameter int VTB    = 72,
   parameter int HREP   = 2,
   parameter int VREP   = 2,
   parameter int TXTPAD = 16,
   parameter bit HSPOL  = 1'b0,
   parameter bit VSPOL  = 1'b0,
   parameter int PF     = 8,
   localparam int HTOT  = HVID + HRB + HFP + HS + HBP + HLB,
   localparam int VTOT  = VVID + VBB + VFP + VS + VBP + VTB,
   localparam int CW    = ($clog2(HVID / HREP) > 0) ? $clog2(HVID / HREP) : 1,
   localparam int RW    = ($clog2(VVID / VREP) > 0) ? $clog2(VVID / VREP) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          text_mode,
   output logic          hsync,
   output logic          vsync,
   output logic          vid_active,
   output logic          border,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          pix_en,
   output logic          eof,
   output logic          fetch_en,
   output logic [CW-1:0] fetch_col,
   output logic [RW-1:0] fetch_row
);

   // One spare bit so that interval end points equal to HTOT/VTOT still fit.
   localparam int HW  = $clog2(HTOT + 1);
   localparam int VW  = $clog2(VTOT + 1);
   localparam int HSW = (HREP > 1) ? $clog2(HREP) : 1;
   localparam int VSW = (VREP > 1) ? $clog2(VREP) : 1;

   localparam logic [HW-1:0]  H_LAST = HW'(HTOT - 1);
   localparam logic [HW-1:0]  H_VID  = HW'(HVID);
   localparam logic [HW-1:0]  H_TLO  = HW'(TXTPAD);
   localparam logic [HW-1:0]  H_THI  = HW'(HVID - TXTPAD);
   localparam logic [HW-1:0]  H_VISR = HW'(HVID + HRB);
   localparam logic [HW-1:0]  H_LB   = HW'(HTOT - HLB);
   localparam logic [HW-1:0]  H_SS   = HW'(HVID + HRB + HFP);
   localparam logic [HW-1:0]  H_SE   = HW'(HVID + HRB + HFP + HS);
   localparam logic [VW-1:0]  V_LAST = VW'(VTOT - 1);
   localparam logic [VW-1:0]  V_VID  = VW'(VVID);
   localparam logic [VW-1:0]  V_VEND = VW'(VVID - 1);
   localparam logic [VW-1:0]  V_VISB = VW'(VVID + VBB);
   localparam logic [VW-1:0]  V_TB   = VW'(VTOT - VTB);
   localparam logic [VW-1:0]  V_SS   = VW'(VVID + VBB + VFP);
   localparam logic [VW-1:0]  V_SE   = VW'(VVID + VBB + VFP + VS);
   localparam logic [HSW-1:0] HSUB_LAST = HSW'(HREP - 1);
   localparam logic [VSW-1:0] VSUB_LAST = VSW'(VREP - 1);

   if ((HVID % HREP != 0) || (VVID % VREP != 0) || (TXTPAD % HREP != 0) ||
       (HREP < 1) || (VREP < 1) || (PF < 1) || (PF > HLB + HBP)) begin : g_bad_param
      $error("vgasync_scaled: illegal parameter combination");
   end

   function automatic logic f_hact(input logic [HW-1:0] h, input logic tm);
      return tm ? ((h >= H_TLO) && (h < H_THI)) : (h < H_VID);
   endfunction

   function automatic logic f_vis(input logic [HW-1:0] h, input logic [VW-1:0] v);
      return ((h < H_VISR) || (h >= H_LB)) && ((v < V_VISB) || (v >= V_TB));
   endfunction

   // ---------------------------------------------------------------- main
   logic [HW-1:0]  r_hpos;
   logic [VW-1:0]  r_vpos;
   logic           r_tm;
   logic [HSW-1:0] r_hsub;   // clock index inside the current VDP pixel
   logic [CW-1:0]  r_colc;   // col value of the current active clock
   logic [VSW-1:0] r_vsub;   // line index inside the current VDP line
   logic [RW-1:0]  r_rowc;   // row value of the current active line

   logic w_hwrap, w_vwrap, w_vact, w_act;

   assign w_hwrap = (r_hpos == H_LAST);
   assign w_vwrap = (r_vpos == V_LAST);
   assign w_vact  = (r_vpos < V_VID);
   assign w_act   = f_hact(r_hpos, r_tm) && w_vact;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hpos     <= '0;
         r_vpos     <= '0;
         r_tm       <= text_mode;
         r_hsub     <= '0;
         r_colc     <= '0;
         r_vsub     <= '0;
         r_rowc     <= '0;
         hsync      <= ~HSPOL;
         vsync      <= ~VSPOL;
         vid_active <= 1'b0;
         border     <= 1'b0;
         col        <= '0;
         row        <= '0;
         pix_en     <= 1'b0;
         eof        <= 1'b0;
      end else begin
         if (w_hwrap) begin
            r_hpos <= '0;
            if (w_vwrap) begin
               r_vpos <= '0;
               r_tm   <= text_mode;   // mode only changes on the frame edge
            end else begin
               r_vpos <= r_vpos + VW'(1);
            end
         end else begin
            r_hpos <= r_hpos + HW'(1);
         end

         // Sub-counters restart on every inactive clock so the next window
         // always begins at col 0, sub 0. col itself holds outside the window.
         if (w_act) begin
            col <= r_colc;
            if (r_hsub == HSUB_LAST) begin
               r_hsub <= '0;
               r_colc <= r_colc + CW'(1);
            end else begin
               r_hsub <= r_hsub + HSW'(1);
            end
         end else begin
            r_hsub <= '0;
            r_colc <= '0;
         end

         if (w_vact) row <= r_rowc;
         if (w_hwrap) begin
            if (w_vwrap) begin
               r_vsub <= '0;
               r_rowc <= '0;
            end else if (w_vact) begin
               if (r_vsub == VSUB_LAST) begin
                  r_vsub <= '0;
                  r_rowc <= r_rowc + RW'(1);
               end else begin
                  r_vsub <= r_vsub + VSW'(1);
               end
            end
         end

         vid_active <= w_act;
         border     <= f_vis(r_hpos, r_vpos) && !w_act;
         pix_en     <= w_act && (r_hsub == '0);
         eof        <= w_hwrap && (r_vpos == V_VEND);
         hsync      <= ((r_hpos >= H_SS) && (r_hpos < H_SE)) ? HSPOL : ~HSPOL;
         vsync      <= ((r_vpos >= V_SS) && (r_vpos < V_SE)) ? VSPOL : ~VSPOL;
      end
   end

`ifdef VGASYNC_PREFETCH_EN
   // ------------------------------------------------------- look-ahead
   // A copy of the main counters started PF clocks ahead. Its sub-counters
   // are preloaded with the state the main counters reach at hpos=PF.
   localparam int PF_NG = (PF < HVID) ? PF : 0;
   localparam int PF_NT = ((PF >= TXTPAD) && (PF < HVID - TXTPAD)) ? PF - TXTPAD : 0;

   logic [HW-1:0]  r_fh;
   logic [VW-1:0]  r_fv;
   logic           r_ftm;
   logic [HSW-1:0] r_fhsub;
   logic [CW-1:0]  r_fcolc;
   logic [VSW-1:0] r_fvsub;
   logic [RW-1:0]  r_frowc;

   logic w_fhwrap, w_fvwrap, w_fvact, w_fact;

   assign w_fhwrap = (r_fh == H_LAST);
   assign w_fvwrap = (r_fv == V_LAST);
   assign w_fvact  = (r_fv < V_VID);
   assign w_fact   = f_hact(r_fh, r_ftm) && w_fvact;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fh      <= HW'(PF);
         r_fv      <= '0;
         r_ftm     <= text_mode;
         r_fhsub   <= text_mode ? HSW'(PF_NT % HREP) : HSW'(PF_NG % HREP);
         r_fcolc   <= text_mode ? CW'(PF_NT / HREP) : CW'(PF_NG / HREP);
         r_fvsub   <= '0;
         r_frowc   <= '0;
         fetch_en  <= 1'b0;
         fetch_col <= '0;
         fetch_row <= '0;
      end else begin
         if (w_fhwrap) begin
            r_fh <= '0;
            if (w_fvwrap) begin
               r_fv  <= '0;
               r_ftm <= text_mode;
            end else begin
               r_fv <= r_fv + VW'(1);
            end
         end else begin
            r_fh <= r_fh + HW'(1);
         end

         if (w_fact) begin
            fetch_col <= r_fcolc;
            if (r_fhsub == HSUB_LAST) begin
               r_fhsub <= '0;
               r_fcolc <= r_fcolc + CW'(1);
            end else begin
               r_fhsub <= r_fhsub + HSW'(1);
            end
         end else begin
            r_fhsub <= '0;
            r_fcolc <= '0;
         end

         if (w_fvact) fetch_row <= r_frowc;
         if (w_fhwrap) begin
            if (w_fvwrap) begin
               r_fvsub <= '0;
               r_frowc <= '0;
            end else if (w_fvact) begin
               if (r_fvsub == VSUB_LAST) begin
                  r_fvsub <= '0;
                  r_frowc <= r_frowc + RW'(1);
               end else begin
                  r_fvsub <= r_fvsub + VSW'(1);
               end
            end
         end

         fetch_en <= w_fact && (r_fhsub == '0);
      end
   end
`else
   assign fetch_en  = 1'b0;
   assign fetch_col = '0;
   assign fetch_row = '0;
`endif

endmodule

// File: tb/tb_vgasync_scaled.sv
`timescale 1ns/1ps
module tb_vgasync_scaled;
   localparam int HVID = 8, HRB = 2, HFP = 2, HS = 3, HBP = 4, HLB = 2;
   localparam int VVID = 4, VBB = 2, VFP = 4, VS = 2, VBP = 3, VTB = 2;
   localparam int HREP = 2, VREP = 2, TXTPAD = 2, PF = 3;
   localparam int HTOT = HVID + HRB + HFP + HS + HBP + HLB;   // 21
   localparam int VTOT = VVID + VBB + VFP + VS + VBP + VTB;   // 17
   localparam int HSS  = HVID + HRB + HFP;
   localparam int VSS  = VVID + VBB + VFP;
   localparam int FRAME = HTOT * VTOT;                        // 357

   logic clk = 1'b0, reset = 1'b1, text_mode = 1'b0;
   logic hsync, vsync, vid_active, border, pix_en, eof, fetch_en;
   logic [1:0] col, fetch_col;
   logic [0:0] row, fetch_row;

   vgasync_scaled #(
      .HVID(HVID), .HRB(HRB), .HFP(HFP), .HS(HS), .HBP(HBP), .HLB(HLB),
      .VVID(VVID), .VBB(VBB), .VFP(VFP), .VS(VS), .VBP(VBP), .VTB(VTB),
      .HREP(HREP), .VREP(VREP), .TXTPAD(TXTPAD), .HSPOL(1'b0), .VSPOL(1'b0), .PF(PF)
   ) dut (
      .clk(clk), .reset(reset), .text_mode(text_mode),
      .hsync(hsync), .vsync(vsync), .vid_active(vid_active), .border(border),
      .col(col), .row(row), .pix_en(pix_en), .eof(eof),
      .fetch_en(fetch_en), .fetch_col(fetch_col), .fetch_row(fetch_row)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: raster position plus the held col/row values.
   int mh = 0, mv = 0;
   bit mtm = 0;
   int e_hs = 1, e_vs = 1, e_act = 0, e_bd = 0, e_col = 0, e_row = 0, e_pix = 0, e_eof = 0;

   task automatic model_edge();
      int lo, hi;
      bit hact, vact, hvis, vvis;
      if (reset) begin
         mh = 0; mv = 0; mtm = text_mode;
         e_hs = 1; e_vs = 1; e_act = 0; e_bd = 0;
         e_col = 0; e_row = 0; e_pix = 0; e_eof = 0;
      end else begin
         lo = mtm ? TXTPAD : 0;
         hi = mtm ? HVID - TXTPAD : HVID;
         hact = (mh >= lo) && (mh < hi);
         vact = (mv < VVID);
         hvis = (mh < HVID + HRB) || (mh >= HTOT - HLB);
         vvis = (mv < VVID + VBB) || (mv >= VTOT - VTB);
         e_act = int'(hact && vact);
         e_bd  = int'(hvis && vvis && !(hact && vact));
         e_pix = 0;
         if (hact && vact) begin
            e_col = (mh - lo) / HREP;
            e_pix = int'(((mh - lo) % HREP) == 0);
         end
         if (vact) e_row = mv / VREP;
         e_hs  = (mh >= HSS && mh < HSS + HS) ? 0 : 1;
         e_vs  = (mv >= VSS && mv < VSS + VS) ? 0 : 1;
         e_eof = int'(mh == HTOT - 1 && mv == VVID - 1);
         mh++;
         if (mh == HTOT) begin
            mh = 0; mv++;
            if (mv == VTOT) begin mv = 0; mtm = text_mode; end
         end
      end
   endtask

`ifdef VGASYNC_PREFETCH_EN
   typedef struct { int en; int c; int r; } pf_t;
   pf_t pfq[$];
`endif
   bit pf_on = 0;

   // One clock: inputs are already set; sample 1ns after the edge.
   task automatic cycle();
      @(posedge clk); #1;
      model_edge();
      chk("hsync", hsync, e_hs);
      chk("vsync", vsync, e_vs);
      chk("vid_active", vid_active, e_act);
      chk("border", border, e_bd);
      chk("col", col, e_col);
      chk("row", row, e_row);
      chk("pix_en", pix_en, e_pix);
      chk("eof", eof, e_eof);
`ifdef VGASYNC_PREFETCH_EN
      if (pf_on) begin
         pfq.push_back('{en: fetch_en, c: fetch_col, r: fetch_row});
         if (pfq.size() > PF) begin
            pf_t p;
            p = pfq.pop_front();
            chk("fetch_en", p.en, e_pix);
            chk("fetch_col", p.c, e_col);
            chk("fetch_row", p.r, e_row);
         end
      end else pfq.delete();
`else
      chk("fetch_en_tied", fetch_en, 0);
      chk("fetch_col_tied", fetch_col, 0);
      chk("fetch_row_tied", fetch_row, 0);
`endif
   endtask

   typedef struct { bit tm; int act; int bd; int c; int pix; int hs; } vec_t;
   vec_t tbl[HTOT];

   initial begin
      int t_col[HTOT];
      logic [20:0] b_act, b_bd, b_pix, b_hs;
      int vs_low, vs_first, eof_cnt, eof1, eof2, hs_f1, hs_f2, vid_l2;
      int rows[4];
      int t_vid, t_lb, t_rb;
      int tcols[$];
      int prev_hs, h, found;

      // Graphics line 0 just after reset release; bit k is clock k.
      t_col = '{0,0,1,1,2,2,3,3,3,3,3,3,3,3,3,3,3,3,3,3,3};
      b_act = 21'h0000FF;
      b_bd  = 21'h180300;
      b_pix = 21'h000055;
      b_hs  = 21'h1F8FFF;
      for (int k = 0; k < HTOT; k++)
         tbl[k] = '{tm: 1'b0, act: int'(b_act[k]), bd: int'(b_bd[k]), c: t_col[k],
                    pix: int'(b_pix[k]), hs: int'(b_hs[k])};

      // Reset for 4 clocks.
      reset = 1; text_mode = 0;
      repeat (4) cycle();
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 1);
      chk("rst_vid", vid_active, 0);
      chk("rst_border", border, 0);
      chk("rst_col", col, 0);
      chk("rst_row", row, 0);
      chk("rst_pix", pix_en, 0);
      chk("rst_eof", eof, 0);

      // Frame 1 (graphics, text_mode raised at i=30), then frame 2 line 0 (text).
      reset = 0;
      vs_low = 0; vs_first = -1; eof_cnt = 0; eof1 = -1; eof2 = -1;
      hs_f1 = -1; hs_f2 = -1; vid_l2 = 0; t_vid = 0; t_lb = 0; t_rb = 0;
      prev_hs = 1;
      for (int i = 0; i < FRAME + 90; i++) begin
         if (i < HTOT) text_mode = tbl[i].tm;
         if (i == 30) text_mode = 1;
         cycle();
         if (i < HTOT) begin
            chk("tbl_vid", vid_active, tbl[i].act);
            chk("tbl_border", border, tbl[i].bd);
            chk("tbl_col", col, tbl[i].c);
            chk("tbl_pix", pix_en, tbl[i].pix);
            chk("tbl_hsync", hsync, tbl[i].hs);
         end
         if (prev_hs == 1 && hsync == 0) begin
            if (hs_f1 < 0) hs_f1 = i; else if (hs_f2 < 0) hs_f2 = i;
         end
         prev_hs = hsync;
         if (i < FRAME) begin
            if (!vsync) begin vs_low++; if (vs_first < 0) vs_first = i; end
            if (eof) begin eof_cnt++; eof1 = i; end
            if (i % HTOT == 0 && i / HTOT < 4) rows[i / HTOT] = row;
            if (i >= 2 * HTOT && i < 3 * HTOT && vid_active) vid_l2++;
         end else begin
            if (eof && eof2 < 0) eof2 = i;
            if (i < FRAME + HTOT) begin
               h = i - FRAME;
               if (vid_active) begin t_vid++; tcols.push_back(col); end
               if (border && (h < TXTPAD || h >= HTOT - HLB)) t_lb++;
               if (border && h >= TXTPAD && h < HVID + HRB) t_rb++;
            end
         end
      end
      chk("hsync_start", hs_f1, 12);
      chk("hsync_period", hs_f2 - hs_f1, HTOT);
      chk("vsync_low_clocks", vs_low, 2 * HTOT);
      chk("vsync_start", vs_first, 10 * HTOT);
      chk("eof_count", eof_cnt, 1);
      chk("eof_pos", eof1, 3 * HTOT + HTOT - 1);
      chk("frame_period", eof2 - eof1, FRAME);
      for (int r = 0; r < 4; r++) chk("row_seq", rows[r], r / 2);
      chk("no_midframe_mode", vid_l2, 8);
      chk("text_vid_width", t_vid, 4);
      chk("text_left_border", t_lb, 4);
      chk("text_right_border", t_rb, 4);
      chk("text_col_count", tcols.size(), 4);
      for (int k = 0; k < tcols.size() && k < 4; k++) chk("text_col_seq", tcols[k], k / 2);

      // Prefetch shift check over two frames, graphics mode throughout.
      text_mode = 0; reset = 1;
      repeat (2) cycle();
      reset = 0; pf_on = 1;
      repeat (2 * FRAME + 10) cycle();
      pf_on = 0;

      // Reset landing inside hsync.
      found = 0;
      for (int k = 0; k < 3 * HTOT && !found; k++) begin
         cycle();
         if (hsync == 0) found = 1;
      end
      chk("hsync_seen_before_reset", found, 1);
      reset = 1;
      cycle();
      chk("midsync_rst_hsync", hsync, 1);
      chk("midsync_rst_vid", vid_active, 0);
      reset = 0;
      cycle();
      chk("post_rst_vid", vid_active, 1);
      chk("post_rst_col", col, 0);
      chk("post_rst_pix", pix_en, 1);

      // Randomised mode changes and occasional resets against the model.
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 199) == 0) text_mode = ~text_mode;
         reset = ($urandom_range(0, 999) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
